// File: rtl/byte_and.sv
// Registered WIDTH-bit bitwise AND with zero / all-ones status decode.
// Optional feature macro: BYTE_AND_POPCNT_EN adds a registered set-bit
// count of the result on port `ones`.
module byte_and #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] o,
    output logic             out_valid,
    output logic             zero,
    output logic             all_ones
`ifdef BYTE_AND_POPCNT_EN
    ,
    output logic [$clog2(WIDTH+1)-1:0] ones
`endif
);

    logic [WIDTH-1:0] and_w;
    logic [WIDTH-1:0] o_q, o_d;
    logic             vld_q;

    assign and_w = a & b;

    // Next result: load a&b only on a qualified input, otherwise hold.
    // The hold path never looks at a/b, so unknowns there stay out of o.
    always_comb begin
        o_d = o_q;
        if (in_valid) begin
            o_d = and_w;
        end
    end

    // Result and valid registers; reset wins over an input in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_q   <= '0;
            vld_q <= 1'b0;
        end else begin
            o_q   <= o_d;
            vld_q <= in_valid;
        end
    end

    assign o         = o_q;
    assign out_valid = vld_q;
    // Flags decode straight off the register so they track o exactly.
    assign zero      = (o_q == '0);
    assign all_ones  = &o_q;

`ifdef BYTE_AND_POPCNT_EN
    localparam int CW = $clog2(WIDTH+1);

    logic [CW-1:0] cnt_w;
    logic [CW-1:0] ones_q, ones_d;

    // Count set bits of the incoming AND so the count lands with o.
    always_comb begin
        cnt_w = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_w = cnt_w + CW'(and_w[i]);
        end
    end

    // Count next-state follows the same load/hold rule as o.
    always_comb begin
        ones_d = ones_q;
        if (in_valid) begin
            ones_d = cnt_w;
        end
    end

    // Count register, cleared with o.
    always_ff @(posedge clk) begin
        if (rst) begin
            ones_q <= '0;
        end else begin
            ones_q <= ones_d;
        end
    end

    assign ones = ones_q;
`endif

endmodule

// File: tb/tb_byte_and.sv
// Scoreboard bench for byte_and: each driven cycle pushes the expected
// registered state; after the edge the task pops it and compares.
module tb_byte_and;

    localparam int W  = 8;
    localparam int CW = $clog2(W+1);

    typedef struct {
        logic [W-1:0] o;
        logic         vld;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] a, b;
    logic [W-1:0] o;
    logic         out_valid, zero, all_ones;
`ifdef BYTE_AND_POPCNT_EN
    logic [CW-1:0] ones;
`endif

    exp_t         sb[$];
    logic [W-1:0] m_o;
    int           n_pass = 0;
    int           n_total = 0;

    byte_and #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .o         (o),
        .out_valid (out_valid),
        .zero      (zero),
        .all_ones  (all_ones)
`ifdef BYTE_AND_POPCNT_EN
        ,
        .ones      (ones)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle, push the reference result, step past the edge.
    task automatic drive(input logic r, input logic v, input logic [W-1:0] aa, input logic [W-1:0] bb);
        exp_t e;
        rst = r; in_valid = v; a = aa; b = bb;
        if (r)      m_o = '0;
        else if (v) m_o = aa & bb;
        e.o = m_o;
        e.vld = !r && v;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic pop(output exp_t e, input string nm);
        n_total++;
        if (sb.size() == 0) begin
            $display("FAIL %s scoreboard empty", nm);
            e.o = 'x; e.vld = 1'bx;
        end else begin
            n_pass++;
            e = sb.pop_front();
        end
    endtask

    task automatic test_reset();
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b1, 8'h5A, 8'hFF);
            pop(e, "reset_sb");
            n_total++; if (o !== e.o) $display("FAIL reset_o got %h exp %h", o, e.o); else n_pass++;
            n_total++; if (out_valid !== 1'b0) $display("FAIL reset_vld got %b exp 0", out_valid); else n_pass++;
            n_total++; if (zero !== 1'b1) $display("FAIL reset_zero got %b exp 1", zero); else n_pass++;
            n_total++; if (all_ones !== 1'b0) $display("FAIL reset_all_ones got %b exp 0", all_ones); else n_pass++;
`ifdef BYTE_AND_POPCNT_EN
            n_total++; if (ones !== '0) $display("FAIL reset_ones got %0d exp 0", ones); else n_pass++;
`endif
        end
    endtask

    task automatic test_basic();
        exp_t e;
        drive(1'b0, 1'b1, 8'h0F, 8'h0A);
        pop(e, "basic_sb");
        n_total++; if (o !== e.o) $display("FAIL basic_o got %h exp %h", o, e.o); else n_pass++;
        n_total++; if (out_valid !== e.vld) $display("FAIL basic_vld got %b exp %b", out_valid, e.vld); else n_pass++;
        n_total++; if (zero !== (e.o == '0)) $display("FAIL basic_zero got %b exp %b", zero, e.o == '0); else n_pass++;
`ifdef BYTE_AND_POPCNT_EN
        n_total++; if (ones !== CW'($countones(e.o))) $display("FAIL basic_ones got %0d exp %0d", ones, $countones(e.o)); else n_pass++;
`endif
    endtask

    task automatic test_hold();
        exp_t e;
        drive(1'b0, 1'b0, 8'hFF, 8'hFF);
        pop(e, "hold_sb");
        n_total++; if (o !== e.o) $display("FAIL hold_o got %h exp %h", o, e.o); else n_pass++;
        n_total++; if (out_valid !== e.vld) $display("FAIL hold_vld got %b exp %b", out_valid, e.vld); else n_pass++;
        // Unknown operands without in_valid must leave o untouched.
        drive(1'b0, 1'b0, 'x, 'x);
        pop(e, "xhold_sb");
        n_total++; if (o !== e.o) $display("FAIL xhold_o got %h exp %h", o, e.o); else n_pass++;
        n_total++; if (all_ones !== (&e.o)) $display("FAIL xhold_all_ones got %b exp %b", all_ones, &e.o); else n_pass++;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic [W-1:0] av[2] = '{8'hFF, 8'hAA};
        logic [W-1:0] bv[2] = '{8'hFF, 8'h55};
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b1, av[i], bv[i]);
            pop(e, "b2b_sb");
            n_total++; if (o !== e.o) $display("FAIL b2b_o[%0d] got %h exp %h", i, o, e.o); else n_pass++;
            n_total++; if (out_valid !== 1'b1) $display("FAIL b2b_vld[%0d] got %b exp 1", i, out_valid); else n_pass++;
            n_total++; if (all_ones !== (&e.o)) $display("FAIL b2b_all_ones[%0d] got %b exp %b", i, all_ones, &e.o); else n_pass++;
            n_total++; if (zero !== (e.o == '0)) $display("FAIL b2b_zero[%0d] got %b exp %b", i, zero, e.o == '0); else n_pass++;
`ifdef BYTE_AND_POPCNT_EN
            n_total++; if (ones !== CW'($countones(e.o))) $display("FAIL b2b_ones[%0d] got %0d exp %0d", i, ones, $countones(e.o)); else n_pass++;
`endif
        end
        drive(1'b0, 1'b0, 8'h00, 8'h00);
        pop(e, "b2b_tail_sb");
        n_total++; if (out_valid !== 1'b0) $display("FAIL b2b_tail_vld got %b exp 0", out_valid); else n_pass++;
    endtask

    task automatic test_reset_priority();
        exp_t e;
        drive(1'b0, 1'b1, 8'h3C, 8'hFF);
        pop(e, "rprio_pre_sb");
        n_total++; if (o !== 8'h3C) $display("FAIL rprio_pre_o got %h exp 3c", o); else n_pass++;
        drive(1'b1, 1'b1, 8'hF0, 8'hF0);
        pop(e, "rprio_sb");
        n_total++; if (o !== 8'h00) $display("FAIL rprio_o got %h exp 00", o); else n_pass++;
        n_total++; if (out_valid !== 1'b0) $display("FAIL rprio_vld got %b exp 0", out_valid); else n_pass++;
        drive(1'b0, 1'b1, 8'hC3, 8'h81);
        pop(e, "rprio_post_sb");
        n_total++; if (o !== 8'h81) $display("FAIL rprio_post_o got %h exp 81", o); else n_pass++;
        n_total++; if (out_valid !== 1'b1) $display("FAIL rprio_post_vld got %b exp 1", out_valid); else n_pass++;
    endtask

    task automatic test_random();
        exp_t e;
        int   bad = 0;
        for (int i = 0; i < 1000; i++) begin
            drive(($urandom_range(0, 31) == 0), $urandom_range(0, 1), W'($urandom), W'($urandom));
            pop(e, "rand_sb");
            n_total++;
            if (o !== e.o || out_valid !== e.vld || zero !== (e.o == '0) || all_ones !== (&e.o)
`ifdef BYTE_AND_POPCNT_EN
                || ones !== CW'($countones(e.o))
`endif
               ) begin
                if (bad < 10)
                    $display("FAIL rand[%0d] got o=%h v=%b z=%b a1=%b exp o=%h v=%b", i, o, out_valid, zero, all_ones, e.o, e.vld);
                bad++;
            end else n_pass++;
        end
    endtask

    initial begin
        m_o = '0;
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0;
        test_reset();
        test_basic();
        test_hold();
        test_back_to_back();
        test_reset_priority();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
